instr_fetch_unit: RTL and testbench

- Sequencer feeding 16-bit instruction words to control_unit: owns the PC, fetches each word from instruction memory over a req/ack handshake, and presents it with a valid/ready handshake.
- Sits between instruction ROM/RAM and control_unit.
- Takes control_unit's pc_sel decision back at consume time to pick the next PC.
- Instruction word layout: [15:10] opcode, [9] register select, [8:0] immediate.

---
 rtl/instr_fetch_unit_pkg.sv | 35 +++
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_pc_calc.sv | 28 ++
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared opcodes, instruction fields, pc_sel encodings and fetch FSM states
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_t;

    localparam logic [1:0] PC_SEL_NEXT = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP = 2'b01;
    localparam logic [1:0] PC_SEL_REL  = 2'b10;
    localparam logic [1:0] PC_SEL_HOLD = 2'b11;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 10;
    localparam int REG_BIT    = 9;
    localparam int IMM_MSB    = 8;
    localparam int IMM_LSB    = 0;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_LD  = 6'h03;
    localparam logic [5:0] OP_ST  = 6'h04;
    localparam logic [5:0] OP_JMP = 6'h05;

    localparam logic REG_X = 1'b0;
    localparam logic REG_Y = 1'b1;

    function automatic logic [8:0] instr_imm(input logic [15:0] word);
        return word[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - memory fetch and instruction hand-off bundle of the fetch unit
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        pc_sel;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic              fetch_err;

    modport master (
        output mem_req, mem_addr, instruction, instr_valid, pc, fetch_err,
        input  mem_ack, mem_rdata, instr_ready, pc_sel, branch_target
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instr_valid, pc, fetch_err,
        output mem_ack, mem_rdata, instr_ready, pc_sel, branch_target
    );
endinterface

// File: rtl/fetch_pc_calc.sv
// rtl/fetch_pc_calc.sv - combinational next-PC selection taken at instruction consume time
module fetch_pc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [8:0]        imm9,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] imm_ext;

    assign imm_ext = {{(ADDR_W-9){imm9[8]}}, imm9};

    // All arithmetic wraps silently modulo 2^ADDR_W.
    always_comb begin
        next_pc = pc;
        case (pc_sel)
            PC_SEL_NEXT: next_pc = pc + ADDR_W'(1);
            PC_SEL_JUMP: next_pc = branch_target;
            PC_SEL_REL:  next_pc = pc + imm_ext;
            PC_SEL_HOLD: next_pc = pc;
            default:     next_pc = pc;
        endcase
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch sequencer; FETCH_TIMEOUT_EN adds a sticky ack-timeout flag
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    instr_fetch_unit_if.master bus
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [15:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] next_pc;
    logic              consume;
    logic              timeout_hit;

    fetch_pc_calc #(.ADDR_W(ADDR_W)) u_pc_calc (
        .pc            (pc_q),
        .pc_sel        (bus.pc_sel),
        .branch_target (bus.branch_target),
        .imm9          (instr_imm(instr_q)),
        .next_pc       (next_pc)
    );

    assign consume = valid_q && bus.instr_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Counts consecutive FETCH cycles without an ack; cleared whenever FETCH is left.
    assign timeout_hit = (state_q == FETCH) && !bus.mem_ack &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == FETCH && !bus.mem_ack && !timeout_hit)
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            else
                wait_cnt_q <= '0;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign bus.fetch_err = err_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (!halt) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    instr_d = bus.mem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else if (timeout_hit) begin
                    // pc is left alone so the retry refetches the same word.
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (consume) begin
                    valid_d = 1'b0;
                    pc_d    = next_pc;
                    if (halt) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // mem_addr and pc are the same register: the address of the outstanding/held word.
    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic halt;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W      (16),
        .RESET_PC    (16'h0000),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .halt (halt),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] rdata;
        int          ack_dly;
        int          rdy_dly;
        logic [1:0]  sel;
        logic [15:0] bt;
        logic [15:0] exp_addr;
        logic [15:0] exp_next;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Next PC from the architectural rules, using plain signed integer arithmetic.
    function automatic logic [15:0] ref_next(input logic [15:0] cur, input logic [1:0] sel,
                                             input logic [15:0] bt, input logic [15:0] word);
        int imm;
        int v;
        imm = int'(word[8:0]);
        if (imm >= 256) imm = imm - 512;
        case (sel)
            2'd0:    v = int'(cur) + 1;
            2'd1:    v = int'(bt);
            2'd2:    v = int'(cur) + imm;
            default: v = int'(cur);
        endcase
        return 16'(v & 32'h0000FFFF);
    endfunction

    task automatic fetch_one(input vec_t v);
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("req_seen", 32'(bus.mem_req), 32'd1);
        check("mem_addr", 32'(bus.mem_addr), 32'(v.exp_addr));
        check("pc", 32'(bus.pc), 32'(v.exp_addr));
        for (int i = 0; i < v.ack_dly; i++) begin
            step();
            check("req_stable", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, v.exp_addr}));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        check("valid_after_ack", 32'(bus.instr_valid), 32'd1);
        check("instruction", 32'(bus.instruction), 32'(v.rdata));
        check("req_dropped", 32'(bus.mem_req), 32'd0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            step();
            check("hold_stable", 32'({bus.instr_valid, bus.mem_req, bus.instruction}),
                  32'({1'b1, 1'b0, v.rdata}));
        end
        bus.instr_ready   = 1'b1;
        bus.pc_sel        = v.sel;
        bus.branch_target = v.bt;
        step();
        bus.instr_ready   = 1'b0;
        bus.pc_sel        = 2'($urandom);
        bus.branch_target = 16'($urandom);
        check("valid_cleared", 32'(bus.instr_valid), 32'd0);
        check("next_pc", 32'(bus.pc), 32'(v.exp_next));
        check("next_req", 32'(bus.mem_req), 32'(!halt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[9];
        vec_t        v;
        logic [15:0] model_pc;

        tbl[0] = '{rdata:{OP_ADD, REG_X, 9'h000}, ack_dly:1, rdy_dly:0, sel:2'b01, bt:16'h0005, exp_addr:16'h0000, exp_next:16'h0005};
        tbl[1] = '{rdata:16'h1234,                ack_dly:0, rdy_dly:1, sel:2'b00, bt:16'h0000, exp_addr:16'h0005, exp_next:16'h0006};
        tbl[2] = '{rdata:{OP_SUB, REG_Y, 9'h1FE}, ack_dly:2, rdy_dly:0, sel:2'b10, bt:16'h7777, exp_addr:16'h0006, exp_next:16'h0004};
        tbl[3] = '{rdata:16'hBEEF,                ack_dly:0, rdy_dly:0, sel:2'b01, bt:16'h0100, exp_addr:16'h0004, exp_next:16'h0100};
        tbl[4] = '{rdata:16'h0F0F,                ack_dly:1, rdy_dly:5, sel:2'b11, bt:16'h2222, exp_addr:16'h0100, exp_next:16'h0100};
        tbl[5] = '{rdata:16'hA5A5,                ack_dly:0, rdy_dly:2, sel:2'b01, bt:16'hFFFF, exp_addr:16'h0100, exp_next:16'hFFFF};
        tbl[6] = '{rdata:16'h5A5A,                ack_dly:3, rdy_dly:0, sel:2'b00, bt:16'h3333, exp_addr:16'hFFFF, exp_next:16'h0000};
        tbl[7] = '{rdata:{OP_JMP, REG_X, 9'h0FF}, ack_dly:0, rdy_dly:0, sel:2'b10, bt:16'h4444, exp_addr:16'h0000, exp_next:16'h00FF};
        tbl[8] = '{rdata:{OP_LD,  REG_Y, 9'h100}, ack_dly:1, rdy_dly:1, sel:2'b10, bt:16'h5555, exp_addr:16'h00FF, exp_next:16'hFFFF};

        rst               = 1'b1;
        halt              = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 16'h0000;
        bus.instr_ready   = 1'b0;
        bus.pc_sel        = 2'b00;
        bus.branch_target = 16'h0000;
        step();
        step();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_instr", 32'(bus.instruction), 32'h0000);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'h0000);
        check("rst_err", 32'(bus.fetch_err), 32'd0);

        rst = 1'b0;
        step();
        check("first_req_latency", 32'(bus.mem_req), 32'd1);

        for (int k = 0; k < 9; k++) fetch_one(tbl[k]);

        // halt raised while a fetch is outstanding: it completes, then the FSM parks.
        halt = 1'b1;
        v = '{rdata:16'hC0DE, ack_dly:2, rdy_dly:1, sel:2'b00, bt:16'h0000, exp_addr:16'hFFFF, exp_next:16'h0000};
        fetch_one(v);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_idle", 32'({bus.mem_req, bus.instr_valid, bus.pc}), 32'({1'b0, 1'b0, 16'h0000}));
        end
        halt = 1'b0;
        step();
        check("resume_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 16'h0000}));

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step();
        check("pre_timeout", 32'({bus.mem_req, bus.fetch_err}), 32'({1'b1, 1'b0}));
        step();
        check("timeout_err", 32'(bus.fetch_err), 32'd1);
        check("timeout_req", 32'(bus.mem_req), 32'd0);
        check("timeout_pc", 32'(bus.pc), 32'h0000);
        step();
        check("retry_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 16'h0000}));
`else
        for (int i = 0; i < 20; i++) step();
        check("no_timeout", 32'({bus.mem_req, bus.fetch_err, bus.mem_addr}), 32'({1'b1, 1'b0, 16'h0000}));
`endif
        v = '{rdata:16'h7E57, ack_dly:0, rdy_dly:0, sel:2'b01, bt:16'h1234, exp_addr:16'h0000, exp_next:16'h1234};
        fetch_one(v);
`ifdef FETCH_TIMEOUT_EN
        check("err_sticky", 32'(bus.fetch_err), 32'd1);
`endif

        model_pc = 16'h1234;
        for (int k = 0; k < 150; k++) begin
            v.rdata    = 16'($urandom);
            v.ack_dly  = int'($urandom_range(0, 3));
            v.rdy_dly  = int'($urandom_range(0, 3));
            v.sel      = 2'($urandom);
            v.bt       = 16'($urandom);
            v.exp_addr = model_pc;
            v.exp_next = ref_next(model_pc, v.sel, v.bt, v.rdata);
            fetch_one(v);
            model_pc = v.exp_next;
        end

        // Reset pulsed while a fetch is outstanding, with an ack arriving during reset.
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_pc", 32'(bus.pc), 32'h0000);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        step();
        step();
        check("rst_ack_ignored", 32'({bus.instr_valid, bus.mem_req, bus.instruction}), 32'({1'b0, 1'b0, 16'h0000}));
        check("rst_clears_err", 32'(bus.fetch_err), 32'd0);
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_req", 32'({bus.mem_req, bus.mem_addr}), 32'({1'b1, 16'h0000}));
        v = '{rdata:16'h0042, ack_dly:0, rdy_dly:0, sel:2'b00, bt:16'h0000, exp_addr:16'h0000, exp_next:16'h0001};
        fetch_one(v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
